// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory
// and loads the IF/ID register, with decode stall and EX redirect/squash support.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [31:0]     fetch_count
);

    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q;
    logic            data_ok_q;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Next fetch address; a stall re-issues pc_q so imem_rdata stays stable.
    always_comb begin
        imem_addr = pc_q + STEP;
        if (redirect_valid) begin
            imem_addr = redirect_target;
        end else if (stall || !data_ok_q) begin
            imem_addr = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            data_ok_q <= 1'b0;
        end else begin
            pc_q      <= imem_addr;
            data_ok_q <= 1'b1;
        end
    end

    // IF/ID load: redirect squashes the wrong-path word and overrides stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (!data_ok_q) begin
            if_id_valid <= 1'b0;
        end else begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc_q;
            if_id_instr <= imem_rdata;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID loads are queued by the stimulus
// and popped by monitors whenever a DUT presents a freshly loaded instruction.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset, reset2;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;

    logic        stall2, redirect_valid2;
    logic [31:0] redirect_pc2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic        if_id_valid2;
    logic [31:0] if_id_pc2, if_id_instr2, fetch_count2;

    exp_t q[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    logic stall_s;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .stall(stall2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .if_id_valid(if_id_valid2), .if_id_pc(if_id_pc2),
        .if_id_instr(if_id_instr2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word i holds 0xA000_0000 + i, one-cycle read.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= mem_word(imem_addr);
        imem_rdata2 <= mem_word(imem_addr2);
        stall_s     <= stall;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_load(input string name, input exp_t e,
                            input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] cnt);
        checks++;
        if (pc !== e.pc || ins !== e.instr || cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h count=%0d expected pc=%h instr=%h count=%0d",
                     name, pc, ins, cnt, e.pc, e.instr, e.cnt);
        end
    endtask

    // Monitors: a new IF/ID load shows as valid with no stall at the loading edge.
    always @(negedge clk) begin
        if (!reset && if_id_valid && !stall_s) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_load", if_id_pc, 32'hxxxx_xxxx);
            end else begin
                chk_load("ifid_load", q.pop_front(), if_id_pc, if_id_instr, fetch_count);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset2 && if_id_valid2) begin
            if (q2.size() == 0) begin
                chk(1'b0, "wrap_unexpected_load", if_id_pc2, 32'hxxxx_xxxx);
            end else begin
                chk_load("wrap_load", q2.pop_front(), if_id_pc2, if_id_instr2, fetch_count2);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] cnt);
        q.push_back('{pc: pc, instr: ins, cnt: cnt});
    endtask

    // Assert reset between edges and check it takes effect without a clock edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk(if_id_valid == 1'b0, "rst_valid", 32'(if_id_valid), 32'd0);
        chk(fetch_count == 32'd0, "rst_count", fetch_count, 32'd0);
        chk(if_id_pc == 32'd0, "rst_pc", if_id_pc, 32'd0);
        chk(if_id_instr == 32'h13, "rst_instr", if_id_instr, 32'h13);
        chk(imem_addr == 32'd0, "rst_imem_addr", imem_addr, 32'd0);
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        step(2);
        chk(if_id_valid == 1'b0, "init_valid", 32'(if_id_valid), 32'd0);
        chk(if_id_instr == 32'h13, "init_instr", if_id_instr, 32'h13);
        chk(fetch_count == 32'd0, "init_count", fetch_count, 32'd0);

        // Free run from 0, plus wrapping instance from 0xFFFF_FFF8
        push(32'h0, 32'hA000_0000, 1);
        push(32'h4, 32'hA000_0001, 2);
        push(32'h8, 32'hA000_0002, 3);
        push(32'hC, 32'hA000_0003, 4);
        q2.push_back('{pc: 32'hFFFF_FFF8, instr: 32'hDFFF_FFFE, cnt: 32'd1});
        q2.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hDFFF_FFFF, cnt: 32'd2});
        q2.push_back('{pc: 32'h0000_0000, instr: 32'hA000_0000, cnt: 32'd3});
        reset = 1'b0; reset2 = 1'b0;
        step(1);
        chk(if_id_valid == 1'b0, "first_edge_bubble", 32'(if_id_valid), 32'd0);
        step(3);
        reset2 = 1'b1;
        step(1);
        chk(fetch_count == 32'd4, "count_after_edge5", fetch_count, 32'd4);
        chk(q2.size() == 0, "wrap_drained", 32'(q2.size()), 32'd0);

        // Mid-run reset, then stall three cycles with pc=8 in IF/ID
        pulse_reset();
        push(32'h0, 32'hA000_0000, 1);
        push(32'h4, 32'hA000_0001, 2);
        push(32'h8, 32'hA000_0002, 3);
        reset = 1'b0;
        step(4);
        stall = 1'b1;
        #1;
        chk(imem_addr == 32'hC, "stall_reissue_addr", imem_addr, 32'hC);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk(if_id_valid && if_id_pc == 32'h8, "stall_hold_pc", if_id_pc, 32'h8);
            chk(fetch_count == 32'd3, "stall_hold_count", fetch_count, 32'd3);
        end
        stall = 1'b0;
        push(32'hC,  32'hA000_0003, 4);
        push(32'h10, 32'hA000_0004, 5);
        step(2);

        // Redirect to 0x40 while IF/ID holds pc=8
        pulse_reset();
        push(32'h0, 32'hA000_0000, 1);
        push(32'h4, 32'hA000_0001, 2);
        push(32'h8, 32'hA000_0002, 3);
        reset = 1'b0;
        step(4);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        chk(if_id_valid == 1'b0, "squash_valid", 32'(if_id_valid), 32'd0);
        chk(if_id_instr == 32'h13, "squash_instr", if_id_instr, 32'h13);
        chk(if_id_pc == 32'h8, "squash_pc_kept", if_id_pc, 32'h8);
        chk(fetch_count == 32'd3, "squash_count", fetch_count, 32'd3);
        push(32'h40, 32'hA000_0010, 4);
        push(32'h44, 32'hA000_0011, 5);
        step(2);

        // Redirect and stall together, misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h103; stall = 1'b1;
        #1;
        chk(imem_addr == 32'h100, "redirect_over_stall_addr", imem_addr, 32'h100);
        step(1);
        redirect_valid = 1'b0; stall = 1'b0;
        chk(if_id_valid == 1'b0, "redirect_over_stall_valid", 32'(if_id_valid), 32'd0);
        chk(fetch_count == 32'd5, "redirect_over_stall_count", fetch_count, 32'd5);
        push(32'h100, 32'hA000_0040, 6);
        push(32'h104, 32'hA000_0041, 7);
        step(2);

        for (int i = 0; i < 20 && (q.size() != 0 || q2.size() != 0); i++) step(1);
        chk(q.size() == 0, "queue_drained", 32'(q.size()), 32'd0);
        chk(q2.size() == 0, "wrap_queue_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
